// File: rtl/counter4_pkg.sv
// Shared helpers for the counter4 slice: a packing function for the
// split Qa..Qd count bits.
package counter4_pkg;

  // Reassemble the four count bits into a nibble, MSB first.
  function automatic logic [3:0] count_of(input logic qd, input logic qc,
                                          input logic qb, input logic qa);
    return {qd, qc, qb, qa};
  endfunction

endpackage

// File: rtl/counter4_if.sv
// Bundle of the counter4 observable outputs; the counter side drives,
// observers sample.
interface counter4_if;
  import counter4_pkg::*;

  logic qa;
  logic qb;
  logic qc;
  logic qd;
  logic rc;

  // Current count as a nibble, for observers.
  function automatic logic [3:0] count();
    return count_of(qd, qc, qb, qa);
  endfunction

  modport master (output qa, output qb, output qc, output qd, output rc);
  modport slave  (input qa, input qb, input qc, input qd, input rc, import count);
endinterface

// File: rtl/counter4_tff_sync.sv
// Synchronous T flip-flop with synchronous active-low load of a reset bit.
module tff_sync #(
  parameter logic POWER_UP = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_bit,
  input  logic t,
  output logic q
);

  logic q_d;
  // Power-up value lets a clk-only simulation start from the reset value.
  logic q_q = POWER_UP;

  // Toggle decision for the next edge.
  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // State register; reset load wins over toggling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= init_bit;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter4.sv
// Free-running 4-bit synchronous up-counter built from a T flip-flop chain,
// with a combinational ripple-carry output at terminal count.
module counter4 #(
  parameter logic [3:0] INIT = 4'h0
) (
  input  logic clk,
  input  logic rst_n,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Rc
);

  logic t_a;
  logic t_b;
  logic t_c;
  logic t_d;

  // Each stage toggles once every lower stage is at one.
  assign t_a = 1'b1;
  assign t_b = Qa;
  assign t_c = Qa & Qb;
  assign t_d = Qa & Qb & Qc;
  assign Rc  = Qd & Qc & Qb & Qa;

  tff_sync #(.POWER_UP(INIT[0])) u_tff_a (
    .clk(clk), .rst_n(rst_n), .init_bit(INIT[0]), .t(t_a), .q(Qa)
  );
  tff_sync #(.POWER_UP(INIT[1])) u_tff_b (
    .clk(clk), .rst_n(rst_n), .init_bit(INIT[1]), .t(t_b), .q(Qb)
  );
  tff_sync #(.POWER_UP(INIT[2])) u_tff_c (
    .clk(clk), .rst_n(rst_n), .init_bit(INIT[2]), .t(t_c), .q(Qc)
  );
  tff_sync #(.POWER_UP(INIT[3])) u_tff_d (
    .clk(clk), .rst_n(rst_n), .init_bit(INIT[3]), .t(t_d), .q(Qd)
  );

endmodule

// File: tb/tb_counter4.sv
// Self-checking bench for counter4: default-INIT and INIT=4'hE instances
// compared against an arithmetic modulo-16 reference model.
module tb_counter4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #25 clk = ~clk;

  counter4_if u_if0 ();
  counter4_if u_if1 ();

  counter4 #(.INIT(4'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .Qa(u_if0.qa), .Qb(u_if0.qb), .Qc(u_if0.qc), .Qd(u_if0.qd), .Rc(u_if0.rc)
  );

  counter4 #(.INIT(4'hE)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .Qa(u_if1.qa), .Qb(u_if1.qb), .Qc(u_if1.qc), .Qd(u_if1.qd), .Rc(u_if1.rc)
  );

  logic [3:0] c0;
  logic [3:0] c1;
  assign c0 = {u_if0.qd, u_if0.qc, u_if0.qb, u_if0.qa};
  assign c1 = {u_if1.qd, u_if1.qc, u_if1.qb, u_if1.qa};

  int checks = 0;
  int errors = 0;
  int m0 = 0;
  int m1 = 14;

  typedef struct {
    logic rst_n;
    int   exp0;
    int   rc0;
    int   exp1;
    int   rc1;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m0 = 0;
      m1 = 14;
    end else begin
      m0 = (m0 + 1) % 16;
      m1 = (m1 + 1) % 16;
    end
    @(negedge clk);
    check("model_cnt0", int'(c0), m0);
    check("model_rc0", int'(u_if0.rc), (m0 == 15) ? 1 : 0);
    check("model_cnt1", int'(c1), m1);
    check("model_rc1", int'(u_if1.rc), (m1 == 15) ? 1 : 0);
  endtask

  initial begin
    vec_t vecs[6];
    int rc_hits;
    int consec;
    logic prev_rc;

    vecs[0] = '{1'b0, 0, 0, 14, 0};
    vecs[1] = '{1'b0, 0, 0, 14, 0};
    vecs[2] = '{1'b1, 1, 0, 15, 1};
    vecs[3] = '{1'b1, 2, 0, 0,  0};
    vecs[4] = '{1'b1, 3, 0, 1,  0};
    vecs[5] = '{1'b1, 4, 0, 2,  0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rst_n = vecs[i].rst_n;
      tick();
      check($sformatf("vec%0d_cnt0", i), int'(c0), vecs[i].exp0);
      check($sformatf("vec%0d_rc0", i), int'(u_if0.rc), vecs[i].rc0);
      check($sformatf("vec%0d_cnt1", i), int'(c1), vecs[i].exp1);
      check($sformatf("vec%0d_rc1", i), int'(u_if1.rc), vecs[i].rc1);
    end

    // Full period from zero: 1..F then 0, carry only at F.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("period_cnt", int'(c0), i % 16);
      check("period_rc", int'(u_if0.rc), (i == 15) ? 1 : 0);
    end

    // 40 edges from a fresh reset: two isolated carry pulses.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rc_hits = 0;
    consec = 0;
    prev_rc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (u_if0.rc) rc_hits++;
      if (u_if0.rc && prev_rc) consec++;
      prev_rc = u_if0.rc;
    end
    check("rc40_hits", rc_hits, 2);
    check("rc40_consec", consec, 0);

    // Reset at count 9.
    for (int k = 0; k < 20 && c0 != 4'h9; k++) tick();
    check("reach9", int'(c0), 9);
    rst_n = 1'b0;
    tick();
    check("rst_at9_cnt", int'(c0), 0);
    rst_n = 1'b1;
    tick();
    check("after_rst9_cnt", int'(c0), 1);

    // Reset at terminal count: carry drops with the load.
    for (int k = 0; k < 20 && c0 != 4'hF; k++) tick();
    check("reachF", int'(c0), 15);
    check("reachF_rc", int'(u_if0.rc), 1);
    rst_n = 1'b0;
    tick();
    check("rst_atF_cnt", int'(c0), 0);
    check("rst_atF_rc", int'(u_if0.rc), 0);
    check("rst_atF_cnt1", int'(c1), 14);
    rst_n = 1'b1;
    tick();
    check("initE_F", int'(c1), 15);
    check("initE_rc", int'(u_if1.rc), 1);
    tick();
    check("initE_wrap", int'(c1), 0);

    // Randomized reset activity against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 11) != 0) ? 1'b1 : 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
